// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/writeback,
// stalls on memReady and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcEn,
  output logic             irWrite,
  output logic             iorD,
  output logic             memWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       aluControl,
  output logic [1:0]       pcSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic pc_write, branch, ir_write_c, mem_write_c, reg_write_c, retire;

  function automatic logic funct_valid(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_valid = 1'b1;
      default:                                               funct_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    retire      = 1'b0;
    iorD        = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluControl  = 3'b010;
    pcSrc       = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        aluSrcB = 2'b01;
        if (memReady) begin
          ir_write_c = 1'b1;
          pc_write   = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iorD = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWB: begin
        memToReg    = 1'b1;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      MEMWR: begin
        // write strobe stays up for the whole stall
        iorD        = 1'b1;
        mem_write_c = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        aluSrcA    = 1'b1;
        aluControl = funct_alu(funct);
        if (funct_valid(funct)) begin
          state_d = ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      ALUWB: begin
        regDst      = 1'b1;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = 3'b110;
        pcSrc      = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pcSrc    = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  // write enables are gated by reset so nothing commits while it is held
  assign pcEn     = reset_n & (pc_write | (branch & zero));
  assign irWrite  = reset_n & ir_write_c;
  assign memWrite = reset_n & mem_write_c;
  assign regWrite = reset_n & reg_write_c;
  assign state    = state_q;
  assign retired  = retired_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule
